// File: rtl/mem_bus_mux_if.sv
// CPU-side request/response bus and slave-side fan-out of the memory bus mux.
// The mux itself uses the slave modport; the CPU (or a bench) uses master.
interface mem_bus_mux_if #(
  parameter int NUM_SLAVES = 4
);
  logic                      mem_valid;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_wstrb;
  logic                      mem_ready;
  logic [31:0]               mem_rdata;
  logic [NUM_SLAVES-1:0]     slv_sel;
  logic [3:0]                slv_wstrb;
  logic [31:0]               slv_addr;
  logic [31:0]               slv_wdata;
  logic [32*NUM_SLAVES-1:0]  slv_rdata;
  logic                      err_pulse;
  logic [7:0]                err_count;
  logic [31:0]               err_addr;

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, slv_rdata,
    output mem_ready, mem_rdata, slv_sel, slv_wstrb, slv_addr, slv_wdata,
           err_pulse, err_count, err_addr
  );

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, slv_rdata,
    input  mem_ready, mem_rdata, slv_sel, slv_wstrb, slv_addr, slv_wdata,
           err_pulse, err_count, err_addr
  );
endinterface

// File: rtl/mem_bus_mux.sv
// Address-decoding memory bus mux: one CPU master to NUM_SLAVES slaves with
// per-slave wait states, single-cycle ready pulse and unmapped-access tracking.
module mem_bus_mux #(
  parameter int                            NUM_SLAVES = 4,
  parameter int                            DEC_LSB    = 12,
  parameter int                            DEC_BITS   = 4,
  parameter logic [NUM_SLAVES*DEC_BITS-1:0] BASE      = {4'h3, 4'h2, 4'h1, 4'h0},
  parameter logic [31:0]                   WAIT       = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_mux_if.slave  bus
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [IDX_W-1:0]     r_idx;
  logic [3:0]           r_wait;
  logic                 r_first;
  logic [31:0]          r_rdata;
  logic                 r_from_err;
  logic [7:0]           r_err_count;
  logic [31:0]          r_err_addr;

  logic [DEC_BITS-1:0]  w_region;
  logic [NUM_SLAVES-1:0] w_match;
  logic [NUM_SLAVES-1:0] w_sel_onehot;
  logic [31:0]          w_rdata_arr [NUM_SLAVES];
  logic [3:0]           w_wait_arr  [NUM_SLAVES];
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;

  assign w_region = bus.mem_addr[DEC_LSB +: DEC_BITS];

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign w_match[gi]      = (w_region == BASE[gi*DEC_BITS +: DEC_BITS]);
      assign w_rdata_arr[gi]  = bus.slv_rdata[32*gi +: 32];
      assign w_wait_arr[gi]   = WAIT[4*gi +: 4];
      assign w_sel_onehot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  // Scan from the top down so the lowest matching slave index is the last write.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.mem_valid) begin
          w_state_next = w_hit ? S_ACCESS : S_ERR;
        end
      end
      S_ACCESS: begin
        if (r_wait == 4'd0) begin
          w_state_next = S_RESP;
        end
      end
      S_ERR:   w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.err_pulse = 1'b0;
    bus.slv_sel   = '0;
    bus.slv_wstrb = 4'h0;
    case (r_state)
      S_ACCESS: begin
        bus.slv_sel   = w_sel_onehot;
        bus.slv_wstrb = r_first ? r_wstrb : 4'h0;
      end
      S_RESP: begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = r_rdata;
        bus.err_pulse = r_from_err;
      end
      default: ;
    endcase
  end

  assign bus.slv_addr  = r_addr;
  assign bus.slv_wdata = r_wdata;
  assign bus.err_count = r_err_count;
  assign bus.err_addr  = r_err_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
      r_idx       <= '0;
      r_wait      <= 4'h0;
      r_first     <= 1'b0;
      r_rdata     <= 32'h0;
      r_from_err  <= 1'b0;
      r_err_count <= 8'h0;
      r_err_addr  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.mem_valid) begin
            r_addr     <= bus.mem_addr;
            r_wdata    <= bus.mem_wdata;
            r_wstrb    <= bus.mem_wstrb;
            r_idx      <= w_hit_idx;
            r_wait     <= w_hit ? w_wait_arr[w_hit_idx] : 4'h0;
            r_first    <= 1'b1;
            r_from_err <= 1'b0;
          end
        end
        S_ACCESS: begin
          r_first <= 1'b0;
          if (r_wait != 4'h0) begin
            r_wait <= r_wait - 4'h1;
          end else begin
            // Writes complete with zero read data.
            r_rdata <= (r_wstrb == 4'h0) ? w_rdata_arr[r_idx] : 32'h0;
          end
        end
        S_ERR: begin
          r_rdata    <= 32'h0;
          r_err_addr <= r_addr;
          r_from_err <= 1'b1;
          if (r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
